// File: rtl/vid_mem_pkg.sv
// Shared types and helpers for the memory burst arbiter: FSM states and the
// round-robin winner search used by rr_pick.
package vid_mem_pkg;

  localparam int LEN_BITS_DEF = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BUSY = 2'd1,
    WR_BUSY = 2'd2,
    GAP     = 2'd3
  } arb_state_e;

  // First set bit at or after ptr, wrapping inside n ports; returns ptr when none is set.
  function automatic logic [2:0] next_rr(input logic [7:0] req_vec, input logic [2:0] ptr,
                                         input int n);
    logic [2:0] win;
    logic [2:0] idx3;
    int         idx;
    win = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        idx  = (int'(ptr) + k) % n;
        idx3 = idx[2:0];
        if (req_vec[idx3]) win = idx3;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: request vector and start pointer in,
// winning index and a found flag out.
module rr_pick
  import vid_mem_pkg::*;
#(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [2:0]         idx_o,
  output logic               found_o
);

  logic [7:0] req_ext;

  always_comb begin
    req_ext = '0;
    req_ext[N_PORTS-1:0] = req_i;
  end

  assign idx_o   = next_rr(req_ext, ptr_i, N_PORTS);
  assign found_o = |req_i;

endmodule

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter sharing one memory-controller burst port between N_PORTS masters.
// Optional burst watchdog enabled by defining ARB_WDOG_EN.
module mem_burst_arbiter
  import vid_mem_pkg::*;
#(
  parameter int N_PORTS       = 4,
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 32,
  parameter int LEN_BITS      = LEN_BITS_DEF,
  parameter int WDOG_CYCLES   = 4096
) (
  input  logic                               mem_clk,
  input  logic                               rst,
  input  logic [N_PORTS-1:0]                 m_rd_req,
  input  logic [N_PORTS-1:0]                 m_wr_req,
  input  logic [N_PORTS*LEN_BITS-1:0]        m_rd_len,
  input  logic [N_PORTS*LEN_BITS-1:0]        m_wr_len,
  input  logic [N_PORTS*ADDR_BITS-1:0]       m_rd_addr,
  input  logic [N_PORTS*ADDR_BITS-1:0]       m_wr_addr,
  input  logic [N_PORTS*MEM_DATA_BITS-1:0]   m_wr_data,
  output logic [MEM_DATA_BITS-1:0]           m_rd_data,
  output logic [N_PORTS-1:0]                 m_rd_valid,
  output logic [N_PORTS-1:0]                 m_wr_dreq,
  output logic [N_PORTS-1:0]                 m_rd_fin,
  output logic [N_PORTS-1:0]                 m_wr_fin,
  output logic                               rd_burst_req,
  output logic                               wr_burst_req,
  output logic [LEN_BITS-1:0]                rd_burst_len,
  output logic [LEN_BITS-1:0]                wr_burst_len,
  output logic [ADDR_BITS-1:0]               rd_burst_addr,
  output logic [ADDR_BITS-1:0]               wr_burst_addr,
  output logic [MEM_DATA_BITS-1:0]           wr_burst_data,
  input  logic                               rd_burst_data_valid,
  input  logic                               wr_burst_data_req,
  input  logic                               rd_burst_finish,
  input  logic                               wr_burst_finish,
  input  logic [MEM_DATA_BITS-1:0]           rd_burst_data,
  output logic [2:0]                         grant_id,
  output logic                               busy,
  output logic                               error
);

  localparam logic [2:0]         LAST_PORT = 3'(N_PORTS - 1);
  localparam logic [N_PORTS-1:0] ONE       = {{(N_PORTS-1){1'b0}}, 1'b1};

  arb_state_e               state_q, state_d;
  logic [2:0]               rr_ptr_q, rr_ptr_d;
  logic [2:0]               grant_q, grant_d;
  logic                     rd_req_q, rd_req_d;
  logic                     wr_req_q, wr_req_d;
  logic [LEN_BITS-1:0]      rd_len_q, rd_len_d, wr_len_q, wr_len_d;
  logic [ADDR_BITS-1:0]     rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  // Per-master slices padded to 8 entries so a 3-bit index is always in range.
  logic [LEN_BITS-1:0]      rd_len_a  [8];
  logic [LEN_BITS-1:0]      wr_len_a  [8];
  logic [ADDR_BITS-1:0]     rd_addr_a [8];
  logic [ADDR_BITS-1:0]     wr_addr_a [8];
  logic [MEM_DATA_BITS-1:0] wr_data_a [8];

  for (genvar g = 0; g < 8; g++) begin : g_slice
    if (g < N_PORTS) begin : g_on
      assign rd_len_a[g]  = m_rd_len[g*LEN_BITS +: LEN_BITS];
      assign wr_len_a[g]  = m_wr_len[g*LEN_BITS +: LEN_BITS];
      assign rd_addr_a[g] = m_rd_addr[g*ADDR_BITS +: ADDR_BITS];
      assign wr_addr_a[g] = m_wr_addr[g*ADDR_BITS +: ADDR_BITS];
      assign wr_data_a[g] = m_wr_data[g*MEM_DATA_BITS +: MEM_DATA_BITS];
    end else begin : g_off
      assign rd_len_a[g]  = '0;
      assign wr_len_a[g]  = '0;
      assign rd_addr_a[g] = '0;
      assign wr_addr_a[g] = '0;
      assign wr_data_a[g] = '0;
    end
  end

  logic [2:0] win_idx, rd_idx;
  logic       win_found, rd_found, win_is_rd;

  rr_pick #(.N_PORTS(N_PORTS)) u_pick_any (
    .req_i(m_rd_req | m_wr_req), .ptr_i(rr_ptr_q), .idx_o(win_idx), .found_o(win_found)
  );

  rr_pick #(.N_PORTS(N_PORTS)) u_pick_rd (
    .req_i(m_rd_req), .ptr_i(rr_ptr_q), .idx_o(rd_idx), .found_o(rd_found)
  );

  // The overall winner gets its read first when it also has a read pending.
  assign win_is_rd = rd_found && (rd_idx == win_idx);

  logic in_rd, in_wr, busy_w, fin_ok, timeout, burst_end;

  assign in_rd     = (state_q == RD_BUSY);
  assign in_wr     = (state_q == WR_BUSY);
  assign busy_w    = in_rd || in_wr;
  assign fin_ok    = (in_rd && rd_burst_finish) || (in_wr && wr_burst_finish);
  assign burst_end = fin_ok || timeout;

`ifdef ARB_WDOG_EN
  logic [31:0] wdog_q, wdog_d;
  logic        err_q, err_d;

  assign timeout = busy_w && (wdog_q == 32'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = (busy_w && !burst_end) ? wdog_q + 32'd1 : 32'd0;
    err_d  = err_q | (timeout & ~fin_ok);
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign error = err_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    rd_len_d  = rd_len_q;
    wr_len_d  = wr_len_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          if (win_is_rd) begin
            state_d   = RD_BUSY;
            rd_req_d  = 1'b1;
            rd_len_d  = rd_len_a[win_idx];
            rd_addr_d = rd_addr_a[win_idx];
          end else begin
            state_d   = WR_BUSY;
            wr_req_d  = 1'b1;
            wr_len_d  = wr_len_a[win_idx];
            wr_addr_d = wr_addr_a[win_idx];
          end
        end
      end
      RD_BUSY, WR_BUSY: begin
        if (burst_end) begin
          state_d  = GAP;
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          rr_ptr_d = (grant_q == LAST_PORT) ? 3'd0 : grant_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_len_q  <= '0;
      wr_len_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      rd_len_q  <= rd_len_d;
      wr_len_q  <= wr_len_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Handshakes reach only the granted master, and never while reset is held.
  logic route_rd, route_wr;
  assign route_rd = !rst && in_rd;
  assign route_wr = !rst && in_wr;

  assign m_rd_valid = (route_rd && rd_burst_data_valid)           ? (ONE << grant_q) : '0;
  assign m_rd_fin   = (route_rd && (rd_burst_finish || timeout))  ? (ONE << grant_q) : '0;
  assign m_wr_dreq  = (route_wr && wr_burst_data_req)             ? (ONE << grant_q) : '0;
  assign m_wr_fin   = (route_wr && (wr_burst_finish || timeout))  ? (ONE << grant_q) : '0;

  assign m_rd_data     = rd_burst_data;
  assign wr_burst_data = in_wr ? wr_data_a[grant_q] : '0;
  assign rd_burst_req  = rd_req_q;
  assign wr_burst_req  = wr_req_q;
  assign rd_burst_len  = rd_len_q;
  assign wr_burst_len  = wr_len_q;
  assign rd_burst_addr = rd_addr_q;
  assign wr_burst_addr = wr_addr_q;
  assign grant_id      = grant_q;
  assign busy          = busy_w;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Randomized bench for mem_burst_arbiter against a transaction-level arbitration model.
module tb_mem_burst_arbiter;

  localparam int N  = 4;
  localparam int D  = 64;
  localparam int A  = 32;
  localparam int L  = 10;
  localparam int WD = 16;
`ifdef ARB_WDOG_EN
  localparam int TMAX = 20;
`else
  localparam int TMAX = 6;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   m_rd_req, m_wr_req;
  logic [N*L-1:0] m_rd_len, m_wr_len;
  logic [N*A-1:0] m_rd_addr, m_wr_addr;
  logic [N*D-1:0] m_wr_data;
  logic [D-1:0]   m_rd_data;
  logic [N-1:0]   m_rd_valid, m_wr_dreq, m_rd_fin, m_wr_fin;
  logic           rd_burst_req, wr_burst_req;
  logic [L-1:0]   rd_burst_len, wr_burst_len;
  logic [A-1:0]   rd_burst_addr, wr_burst_addr;
  logic [D-1:0]   wr_burst_data, rd_burst_data;
  logic           rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish;
  logic [2:0]     grant_id;
  logic           busy, error;

  mem_burst_arbiter #(
    .N_PORTS(N), .MEM_DATA_BITS(D), .ADDR_BITS(A), .LEN_BITS(L), .WDOG_CYCLES(WD)
  ) dut (
    .mem_clk(clk), .rst(rst),
    .m_rd_req(m_rd_req), .m_wr_req(m_wr_req),
    .m_rd_len(m_rd_len), .m_wr_len(m_wr_len),
    .m_rd_addr(m_rd_addr), .m_wr_addr(m_wr_addr),
    .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
    .m_rd_valid(m_rd_valid), .m_wr_dreq(m_wr_dreq),
    .m_rd_fin(m_rd_fin), .m_wr_fin(m_wr_fin),
    .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
    .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
    .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data),
    .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
    .rd_burst_data(rd_burst_data),
    .grant_id(grant_id), .busy(busy), .error(error)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one burst in flight at a time, a single cool-down cycle after it,
  // and a rotating search start that moves past whoever was served last.
  bit           in_flight, cooldown, is_rd, exp_err;
  int           ptr, gnt, age, target;
  logic [L-1:0] e_rlen, e_wlen;
  logic [A-1:0] e_raddr, e_waddr;

  function automatic bit timed_out();
`ifdef ARB_WDOG_EN
    return in_flight && (age == WD - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge(input int mode);
    bit done, t, hit;
    int idx;
    if (rst) begin
      in_flight = 0; cooldown = 0; is_rd = 0; exp_err = 0;
      ptr = 0; gnt = 0; age = 0;
      e_rlen = '0; e_wlen = '0; e_raddr = '0; e_waddr = '0;
    end else if (in_flight) begin
      done = is_rd ? rd_burst_finish : wr_burst_finish;
      t    = timed_out();
      if (done || t) begin
        if (t && !done) exp_err = 1;
        in_flight = 0;
        cooldown  = 1;
        ptr       = (gnt + 1) % N;
      end else begin
        age++;
      end
    end else if (cooldown) begin
      cooldown = 0;
    end else begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (!hit && (m_rd_req[idx] || m_wr_req[idx])) begin
          hit   = 1;
          gnt   = idx;
          is_rd = m_rd_req[idx];
          if (is_rd) begin
            e_rlen  = m_rd_len[idx*L +: L];
            e_raddr = m_rd_addr[idx*A +: A];
          end else begin
            e_wlen  = m_wr_len[idx*L +: L];
            e_waddr = m_wr_addr[idx*A +: A];
          end
        end
      end
      if (hit) begin
        in_flight = 1;
        age       = 0;
        target    = (mode == 0) ? 5 : $urandom_range(TMAX, 1);
      end
    end
  endtask

  task automatic drive(input int mode, input int cyc);
    rst = (cyc < 3) || (mode == 3 && $urandom_range(63) == 0);
    for (int i = 0; i < N; i++) begin
      m_rd_len[i*L +: L]  = L'($urandom);
      m_wr_len[i*L +: L]  = L'($urandom);
      m_rd_addr[i*A +: A] = A'($urandom);
      m_wr_addr[i*A +: A] = A'($urandom);
      m_wr_data[i*D +: D] = {$urandom, $urandom};
    end
    case (mode)
      0: begin
        m_rd_req = 4'b0010; m_wr_req = 4'b0000;
        m_rd_len[L +: L] = 10'd1; m_rd_addr[A +: A] = 32'h100;
      end
      1: begin m_rd_req = 4'b0000; m_wr_req = 4'b1111; end
      2: begin m_rd_req = 4'b0100; m_wr_req = 4'b0100; end
      default: begin
        m_rd_req = N'($urandom) & N'($urandom);
        m_wr_req = N'($urandom) & N'($urandom);
      end
    endcase
    rd_burst_data       = {$urandom, $urandom};
    rd_burst_data_valid = 1'($urandom);
    wr_burst_data_req   = 1'($urandom);
    rd_burst_finish     = in_flight && is_rd && (age + 1 == target);
    wr_burst_finish     = in_flight && !is_rd && (age + 1 == target);
    if (mode >= 2 && $urandom_range(3) == 0) begin
      if (in_flight) begin
        if (is_rd) wr_burst_finish = 1'b1;
        else       rd_burst_finish = 1'b1;
      end else begin
        rd_burst_finish = 1'($urandom);
        wr_burst_finish = 1'($urandom);
      end
    end
  endtask

  task automatic check_routing();
    logic [N-1:0] one;
    bit r, w;
    one = {{(N-1){1'b0}}, 1'b1} << gnt;
    r   = !rst && in_flight && is_rd;
    w   = !rst && in_flight && !is_rd;
    chk("m_rd_valid", 64'(m_rd_valid), (r && rd_burst_data_valid) ? 64'(one) : 64'd0);
    chk("m_rd_fin", 64'(m_rd_fin), (r && (rd_burst_finish || timed_out())) ? 64'(one) : 64'd0);
    chk("m_wr_dreq", 64'(m_wr_dreq), (w && wr_burst_data_req) ? 64'(one) : 64'd0);
    chk("m_wr_fin", 64'(m_wr_fin), (w && (wr_burst_finish || timed_out())) ? 64'(one) : 64'd0);
    chk("wr_burst_data", wr_burst_data, (in_flight && !is_rd) ? m_wr_data[gnt*D +: D] : 64'd0);
    chk("m_rd_data", m_rd_data, rd_burst_data);
  endtask

  task automatic check_regs();
    chk("rd_burst_req", 64'(rd_burst_req), 64'(in_flight && is_rd));
    chk("wr_burst_req", 64'(wr_burst_req), 64'(in_flight && !is_rd));
    chk("grant_id", 64'(grant_id), 64'(gnt));
    chk("busy", 64'(busy), 64'(in_flight));
    chk("rd_burst_len", 64'(rd_burst_len), 64'(e_rlen));
    chk("rd_burst_addr", 64'(rd_burst_addr), 64'(e_raddr));
    chk("wr_burst_len", 64'(wr_burst_len), 64'(e_wlen));
    chk("wr_burst_addr", 64'(wr_burst_addr), 64'(e_waddr));
    chk("error", 64'(error), 64'(exp_err));
  endtask

  int mode_len [4] = '{40, 80, 60, 700};

  initial begin
    int cyc;
    rst = 1'b1;
    m_rd_req = '0; m_wr_req = '0;
    m_rd_len = '0; m_wr_len = '0; m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0;
    rd_burst_data = '0; rd_burst_data_valid = 1'b0; wr_burst_data_req = 1'b0;
    rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
    in_flight = 0; cooldown = 0; is_rd = 0; exp_err = 0;
    ptr = 0; gnt = 0; age = 0; target = 1;
    e_rlen = '0; e_wlen = '0; e_raddr = '0; e_waddr = '0;
    cyc = 0;
    for (int mode = 0; mode < 4; mode++) begin
      for (int c = 0; c < mode_len[mode]; c++) begin
        @(negedge clk);
        drive(mode, cyc);
        #1;
        check_routing();
        @(posedge clk);
        model_edge(mode);
        #1;
        check_regs();
        cyc++;
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
